// File: rtl/segment_transition_ctrl.sv
// Two-segment playback sequencer: read index, repetition counter and segment-change requests.
// Define SEGMENT_TRANSITION_GPIO_EN to build the GPIO transition mode (0x02).
module segment_transition_ctrl #(
    parameter int W_IDX  = 13,
    parameter int W_REP  = 16,
    parameter int W_TIME = 56
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              STEP,
    input  logic              UPDATE_SETTINGS,
    input  logic              REQ_RD_SEGMENT,
    input  logic [7:0]        TRANSITION_MODE,
    input  logic [63:0]       TRANSITION_VALUE,
    input  logic [W_IDX-1:0]  CYCLE0,
    input  logic [W_IDX-1:0]  CYCLE1,
    input  logic [W_REP-1:0]  REP0,
    input  logic [W_REP-1:0]  REP1,
    input  logic [W_TIME-1:0] SYS_TIME,
    input  logic [3:0]        GPIO_IN,
    output logic              SEGMENT,
    output logic [W_IDX-1:0]  IDX,
    output logic              STOP,
    output logic              PENDING,
    output logic              SWAP
);

    typedef enum logic [1:0] {M_SYNC, M_TIME, M_GPIO, M_EXT} mode_t;

    mode_t             pend_mode;
    logic              pend_seg;
    logic [W_TIME-1:0] pend_target;
    logic [W_REP-1:0]  loop_cnt;
    logic              ext_mode;

    logic [W_IDX-1:0]  cyc_cur;
    logic [W_REP-1:0]  rep_cur;
    logic              wrap;
    logic              exhaust;
    logic              swap_cond;
    logic              mode_ok;
    mode_t             mode_dec;
    logic              req_accept;

`ifdef SEGMENT_TRANSITION_GPIO_EN
    logic [3:0]        gpio_prev;
    logic              edge_flag;
    logic              gpio_rise;

    assign gpio_rise = GPIO_IN[pend_target[1:0]] & ~gpio_prev[pend_target[1:0]];

    logic unused_bits;
    assign unused_bits = ^TRANSITION_VALUE[63:W_TIME];
`else
    logic unused_bits;
    assign unused_bits = ^{TRANSITION_VALUE[63:W_TIME], GPIO_IN};
`endif

    always_comb begin
        cyc_cur   = SEGMENT ? CYCLE1 : CYCLE0;
        rep_cur   = SEGMENT ? REP1 : REP0;
        // a CYCLE shrunk below the current index still ends the loop
        wrap      = !STOP && (IDX >= cyc_cur);
        exhaust   = wrap && !(&rep_cur) && (loop_cnt == rep_cur);

        swap_cond = 1'b0;
        case (pend_mode)
            M_SYNC: swap_cond = wrap || STOP;
            M_TIME: swap_cond = (SYS_TIME >= pend_target);
            M_GPIO: begin
`ifdef SEGMENT_TRANSITION_GPIO_EN
                swap_cond = edge_flag;
`else
                swap_cond = 1'b0;
`endif
            end
            M_EXT:  swap_cond = 1'b1;
            default: swap_cond = 1'b0;
        endcase

        mode_ok  = 1'b1;
        mode_dec = M_SYNC;
        case (TRANSITION_MODE)
            8'h00: mode_dec = M_SYNC;
            8'h01: mode_dec = M_TIME;
`ifdef SEGMENT_TRANSITION_GPIO_EN
            8'h02: mode_dec = M_GPIO;
`endif
            8'hF0: mode_dec = M_EXT;
            default: mode_ok = 1'b0;
        endcase

        req_accept = UPDATE_SETTINGS && mode_ok &&
                     ((REQ_RD_SEGMENT != SEGMENT) || (mode_dec == M_EXT));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEGMENT     <= 1'b0;
            IDX         <= '0;
            STOP        <= 1'b0;
            PENDING     <= 1'b0;
            SWAP        <= 1'b0;
            loop_cnt    <= '0;
            ext_mode    <= 1'b0;
            pend_mode   <= M_SYNC;
            pend_seg    <= 1'b0;
            pend_target <= '0;
`ifdef SEGMENT_TRANSITION_GPIO_EN
            gpio_prev   <= '0;
            edge_flag   <= 1'b0;
`endif
        end else begin
            SWAP <= 1'b0;
            if (STEP && PENDING && swap_cond) begin
                SEGMENT  <= pend_seg;
                IDX      <= '0;
                loop_cnt <= '0;
                STOP     <= 1'b0;
                PENDING  <= 1'b0;
                SWAP     <= 1'b1;
                if (pend_mode == M_EXT) ext_mode <= 1'b1;
            end else if (STEP && !STOP) begin
                if (!wrap) begin
                    IDX <= IDX + 1'b1;
                end else if (!exhaust) begin
                    IDX      <= '0;
                    loop_cnt <= loop_cnt + 1'b1;
                end else if (ext_mode) begin
                    // ext mode ping-pongs between segments instead of stopping
                    SEGMENT  <= ~SEGMENT;
                    IDX      <= '0;
                    loop_cnt <= '0;
                    SWAP     <= 1'b1;
                end else begin
                    STOP <= 1'b1;
                end
            end

`ifdef SEGMENT_TRANSITION_GPIO_EN
            gpio_prev <= GPIO_IN;
            if (PENDING && pend_mode == M_GPIO && gpio_rise) edge_flag <= 1'b1;
`endif

            // a request in the same cycle as a swap is latched after it (last wins)
            if (req_accept) begin
                PENDING     <= 1'b1;
                pend_mode   <= mode_dec;
                pend_seg    <= REQ_RD_SEGMENT;
                pend_target <= TRANSITION_VALUE[W_TIME-1:0];
                if (mode_dec != M_EXT) ext_mode <= 1'b0;
`ifdef SEGMENT_TRANSITION_GPIO_EN
                edge_flag   <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Directed bench for segment_transition_ctrl: behavioural model compared every cycle plus literal checkpoints.
module tb_segment_transition_ctrl;

    localparam int W_IDX  = 13;
    localparam int W_REP  = 16;
    localparam int W_TIME = 56;
`ifdef SEGMENT_TRANSITION_GPIO_EN
    localparam bit GPIO_EN = 1'b1;
`else
    localparam bit GPIO_EN = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              STEP = 1'b0;
    logic              UPDATE_SETTINGS = 1'b0;
    logic              REQ_RD_SEGMENT = 1'b0;
    logic [7:0]        TRANSITION_MODE = '0;
    logic [63:0]       TRANSITION_VALUE = '0;
    logic [W_IDX-1:0]  CYCLE0 = '0, CYCLE1 = '0;
    logic [W_REP-1:0]  REP0 = '1, REP1 = '1;
    logic [W_TIME-1:0] SYS_TIME = '0;
    logic [3:0]        GPIO_IN = '0;
    logic              SEGMENT, STOP, PENDING, SWAP;
    logic [W_IDX-1:0]  IDX;

    segment_transition_ctrl #(.W_IDX(W_IDX), .W_REP(W_REP), .W_TIME(W_TIME)) dut (
        .CLK(CLK), .RST(RST), .STEP(STEP), .UPDATE_SETTINGS(UPDATE_SETTINGS),
        .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .TRANSITION_MODE(TRANSITION_MODE),
        .TRANSITION_VALUE(TRANSITION_VALUE), .CYCLE0(CYCLE0), .CYCLE1(CYCLE1),
        .REP0(REP0), .REP1(REP1), .SYS_TIME(SYS_TIME), .GPIO_IN(GPIO_IN),
        .SEGMENT(SEGMENT), .IDX(IDX), .STOP(STOP), .PENDING(PENDING), .SWAP(SWAP)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: state kept as plain integers, loops counted as completed loops.
    int  m_seg, m_idx, m_stop, m_pend, m_swap, m_loops, m_ext, m_flag;
    int  m_mode, m_req_seg, m_sel;
    longint unsigned m_target;
    logic [3:0] m_gprev;

    always @(posedge CLK) begin
        int cyc, rep, last_loop, done, go, acc, fl;
        bit inf, mode_valid;
        if (RST) begin
            m_seg = 0; m_idx = 0; m_stop = 0; m_pend = 0; m_swap = 0;
            m_loops = 0; m_ext = 0; m_flag = 0; m_gprev = '0;
            m_mode = 0; m_req_seg = 0; m_sel = 0; m_target = 0;
        end else begin
            cyc  = m_seg ? int'(CYCLE1) : int'(CYCLE0);
            rep  = m_seg ? int'(REP1) : int'(REP0);
            inf  = (rep == (1 << W_REP) - 1);
            done = (m_stop == 0) && (m_idx >= cyc);
            go   = 0;
            if (STEP && m_pend) begin
                if (m_mode == 8'h00) go = done || m_stop;
                else if (m_mode == 8'h01) go = (longint'(SYS_TIME) >= longint'(m_target));
                else if (m_mode == 8'h02) go = m_flag;
                else go = 1;
            end
            mode_valid = (TRANSITION_MODE == 8'h00) || (TRANSITION_MODE == 8'h01) ||
                         (TRANSITION_MODE == 8'hF0) || (GPIO_EN && TRANSITION_MODE == 8'h02);
            acc = UPDATE_SETTINGS && mode_valid &&
                  ((int'(REQ_RD_SEGMENT) != m_seg) || TRANSITION_MODE == 8'hF0);
            fl  = m_flag;
            if (GPIO_EN && m_pend && m_mode == 8'h02 && GPIO_IN[m_sel] && !m_gprev[m_sel]) fl = 1;

            m_swap = 0;
            if (go) begin
                if (m_mode == 8'hF0) m_ext = 1;
                m_seg = m_req_seg; m_idx = 0; m_loops = 0; m_stop = 0; m_pend = 0; m_swap = 1;
            end else if (STEP && !m_stop) begin
                if (done) begin
                    m_loops++;
                    last_loop = !inf && (m_loops > rep);
                    if (!last_loop) m_idx = 0;
                    else if (m_ext) begin
                        m_seg = 1 - m_seg; m_idx = 0; m_loops = 0; m_swap = 1;
                    end else m_stop = 1;
                end else m_idx++;
            end
            m_flag = fl;
            if (acc) begin
                m_pend = 1; m_mode = TRANSITION_MODE; m_req_seg = REQ_RD_SEGMENT;
                m_target = TRANSITION_VALUE[W_TIME-1:0]; m_sel = TRANSITION_VALUE[1:0];
                m_flag = 0;
                if (TRANSITION_MODE != 8'hF0) m_ext = 0;
            end
            m_gprev = GPIO_IN;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_segment", SEGMENT, m_seg);
            chk("m_idx", IDX, m_idx);
            chk("m_stop", STOP, m_stop);
            chk("m_pending", PENDING, m_pend);
            chk("m_swap", SWAP, m_swap);
        end
    end

    task automatic tick(input bit s, input bit u);
        STEP = s; UPDATE_SETTINGS = u;
        @(posedge CLK); #1;
        STEP = 1'b0; UPDATE_SETTINGS = 1'b0;
    endtask

    task automatic req(input bit seg, input logic [7:0] mode, input logic [63:0] val);
        REQ_RD_SEGMENT = seg; TRANSITION_MODE = mode; TRANSITION_VALUE = val;
        tick(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        RST = 1'b1; tick(1'b0, 1'b0); RST = 1'b0;
    endtask

    int exp_fr[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};
    int exp_fi[5]  = '{1, 0, 1, 1, 1};
    int exp_fs[5]  = '{0, 0, 0, 1, 1};
    int exp_ex[5]  = '{1, 1, 0, 0, 1};

    initial begin
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_outputs", {SEGMENT, IDX, STOP, PENDING, SWAP}, 0);
        RST = 1'b0;

        // free-run
        CYCLE0 = 3; REP0 = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            chk("freerun_idx", IDX, exp_fr[i]);
        end
        chk("freerun_seg_stop", {SEGMENT, STOP}, 0);

        // finite repetition then sync-index swap out of STOP
        do_reset();
        CYCLE0 = 1; REP0 = 1; CYCLE1 = 5; REP1 = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            chk("finite_idx", IDX, exp_fi[i]);
            chk("finite_stop", STOP, exp_fs[i]);
        end
        req(1'b0, 8'h00, 64'd0);
        chk("same_seg_ignored", PENDING, 0);
        req(1'b1, 8'h55, 64'd0);
        chk("unknown_mode_ignored", PENDING, 0);
        req(1'b1, 8'h00, 64'd0);
        chk("stop_req_pending", PENDING, 1);
        tick(1'b1, 1'b0);
        chk("stop_swap", {SEGMENT, IDX, STOP, PENDING, SWAP}, {1'b1, 13'd0, 1'b0, 1'b0, 1'b1});
        tick(1'b0, 1'b0);
        chk("swap_one_cycle", SWAP, 0);

        // sync-index: wait for the wrap
        do_reset();
        CYCLE0 = 7; REP0 = 16'hFFFF;
        tick(1'b1, 1'b0); tick(1'b1, 1'b0);
        req(1'b1, 8'h00, 64'd0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("sync_still_pending", {PENDING, SEGMENT, IDX}, {1'b1, 1'b0, 13'd7});
        tick(1'b1, 1'b0);
        chk("sync_swap", {SEGMENT, IDX, SWAP}, {1'b1, 13'd0, 1'b1});

        // system time
        do_reset();
        req(1'b1, 8'h01, 64'd1000);
        SYS_TIME = 990; tick(1'b1, 1'b0);
        SYS_TIME = 999; tick(1'b1, 1'b0);
        chk("time_before_target", {SEGMENT, PENDING}, 2'b01);
        SYS_TIME = 1000; tick(1'b1, 1'b0);
        chk("time_at_target", {SEGMENT, SWAP}, 2'b11);
        req(1'b0, 8'h01, 64'd5);
        SYS_TIME = 900; tick(1'b1, 1'b0);
        chk("time_past_target", {SEGMENT, SWAP, PENDING}, 3'b010);

        // GPIO
        do_reset();
        CYCLE0 = 7;
        GPIO_IN = 4'h0; tick(1'b0, 1'b0);
        GPIO_IN = 4'h4; tick(1'b0, 1'b0);
        req(1'b1, 8'h02, 64'd2);
        if (GPIO_EN) begin
            tick(1'b1, 1'b0);
            chk("gpio_early_edge", {SEGMENT, PENDING}, 2'b01);
            GPIO_IN = 4'h0; tick(1'b0, 1'b0);
            GPIO_IN = 4'h4; tick(1'b0, 1'b0);
            tick(1'b1, 1'b0);
            chk("gpio_edge_swap", {SEGMENT, SWAP}, 2'b11);
        end else begin
            chk("gpio_disabled", PENDING, 0);
            tick(1'b1, 1'b0);
            chk("gpio_disabled_seg", SEGMENT, 0);
        end
        GPIO_IN = 4'h0;

        // EXT alternation
        do_reset();
        CYCLE0 = 1; CYCLE1 = 1; REP0 = 0; REP1 = 0;
        req(1'b1, 8'hF0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0);
            chk("ext_seg", SEGMENT, exp_ex[i]);
        end

        // last request wins; same-cycle STEP+UPDATE; reset drops pending
        do_reset();
        CYCLE0 = 7; REP0 = 16'hFFFF; SYS_TIME = 100;
        req(1'b1, 8'h01, 64'd0);
        req(1'b1, 8'h01, 64'd1000000);
        tick(1'b1, 1'b0);
        chk("last_wins", {SEGMENT, PENDING}, 2'b01);
        REQ_RD_SEGMENT = 1'b1; TRANSITION_MODE = 8'h01; TRANSITION_VALUE = 64'd0;
        tick(1'b1, 1'b1);
        chk("step_upd_same_cycle", {SEGMENT, PENDING, IDX}, {1'b0, 1'b1, 13'd2});
        tick(1'b1, 1'b0);
        chk("step_upd_next", SEGMENT, 1);
        req(1'b0, 8'h01, 64'd1000000);
        tick(1'b1, 1'b0);
        RST = 1'b1; tick(1'b0, 1'b0);
        chk("rst_while_pending", {SEGMENT, IDX, STOP, PENDING, SWAP}, 0);
        RST = 1'b0;
        tick(1'b0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
